// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_MAX = 32;

  // Width of the bit counter: enough to count 0..width-1, never below one bit.
  function automatic int cnt_w(input int width);
    if (width <= 2) begin
      return 1;
    end
    return $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder: the arithmetic cell that the serial sequencer drives.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: accepts two WIDTH-bit operands, streams them LSB-first
// through one full-adder cell with a registered carry, and returns sum,
// carry-out and signed overflow over a valid/ready handshake.
// Optional subtraction mode is enabled by defining SERIAL_ADDER_SUB_EN,
// which adds a 'sub' input sampled with the operands.
module bit_serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;

  logic             cell_sum;
  logic             cell_cout;
  logic             last_bit;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] b_load;
  logic             cin_load;

  full_adder_cell u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (cell_sum),
    .cout (cell_cout)
  );

  // Operand B and carry-in as loaded at transfer; subtraction uses a + ~b + 1.
`ifdef SERIAL_ADDER_SUB_EN
  always_comb begin
    b_load   = sub ? ~b : b;
    cin_load = sub ? 1'b1 : cin_in;
  end
`else
  always_comb begin
    b_load   = b;
    cin_load = cin_in;
  end
`endif

  // Result shift register after inserting the current sum bit at the MSB.
  always_comb begin
    res_next            = res_sh_q >> 1;
    res_next[WIDTH-1]   = cell_sum;
  end

  assign last_bit = (bit_cnt_q == CW'(WIDTH - 1));

  // Next-state and datapath updates for IDLE -> RUN -> DONE sequencing.
  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    res_sh_d    = res_sh_q;
    carry_d     = carry_q;
    bit_cnt_d   = bit_cnt_q;
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d    = a;
          b_sh_d    = b_load;
          carry_d   = cin_load;
          bit_cnt_d = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        res_sh_d  = res_next;
        carry_d   = cell_cout;
        a_sh_d    = a_sh_q >> 1;
        b_sh_d    = b_sh_q >> 1;
        bit_cnt_d = bit_cnt_q + CW'(1);
        if (last_bit) begin
          // carry_q here is the carry into the MSB; compare with carry out.
          sum_d       = res_next;
          carry_out_d = cell_cout;
          overflow_d  = carry_q ^ cell_cout;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything and aborts any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_sh_q    <= '0;
      carry_q     <= 1'b0;
      bit_cnt_q   <= '0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      res_sh_q    <= res_sh_d;
      carry_q     <= carry_d;
      bit_cnt_q   <= bit_cnt_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule
